// File: rtl/uart_tx_word_splitter_if.sv
// Register-write bus plus chunk stream between the bus side and the word splitter.
// Handshake: a chunk transfers on a posedge where out_valid && out_ready are both 1;
// once out_valid rises it stays high, with data_out/out_last held, until the transfer.
interface uart_tx_word_splitter_if #(
  parameter int ADDR_W = 8,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8
) ();
  logic [ADDR_W-1:0] address;
  logic              wr_en;
  logic [IN_W-1:0]   data_in;
  logic [1:0]        WLS;
  logic              in_ready;
  logic [OUT_W-1:0]  data_out;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              overrun;
  logic              ovr_clr;

  modport master (
    output address, wr_en, data_in, WLS, out_ready, ovr_clr,
    input  in_ready, data_out, out_valid, out_last, overrun
  );

  modport slave (
    input  address, wr_en, data_in, WLS, out_ready, ovr_clr,
    output in_ready, data_out, out_valid, out_last, overrun
  );
endinterface

// File: rtl/uart_tx_word_splitter.sv
// Splits one IN_W-bit written word into 5..8-bit characters (width from WLS) and
// streams them to the UART transmitter, LSB chunk first unless MSB_FIRST is set.
// Every output is decoded from registers, so out_ready never reaches out_valid or data_out.
module uart_tx_word_splitter #(
  parameter int              IN_W      = 16,
  parameter int              OUT_W     = 8,
  parameter int              ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] TX_ADDR = 8'h00,
  parameter bit              MSB_FIRST = 1'b0
) (
  input  logic                   m_clk,
  input  logic                   reset,
  uart_tx_word_splitter_if.slave bus,
  output logic                   state_dbg
);
  // Chunk counts for each character width, rounded up.
  localparam int N5    = (IN_W + 4) / 5;
  localparam int N6    = (IN_W + 5) / 6;
  localparam int N7    = (IN_W + 6) / 7;
  localparam int N8    = (IN_W + 7) / 8;
  localparam int CNT_W = $clog2(N5 + 1);
  localparam int SH_W  = $clog2(IN_W) + 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   word_q, word_d;
  logic [1:0]        wls_q, wls_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              overrun_q, overrun_d;

  logic              load;
  logic [CNT_W-1:0]  n_load;
  logic [3:0]        width;
  logic [CNT_W-1:0]  sel;
  logic [SH_W-1:0]   shamt;
  logic [IN_W-1:0]   shifted;
  logic [7:0]        chunk_mask;
  logic [7:0]        chunk;

  // State, latched word and sticky overrun; reset discards any partial word.
  always_ff @(posedge m_clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      word_q    <= '0;
      wls_q     <= '0;
      n_q       <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      wls_q     <= wls_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  // Next state: load in IDLE, advance the chunk index on each accepted chunk.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    wls_d     = wls_q;
    n_d       = n_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    load      = bus.wr_en && (bus.address == TX_ADDR);
    case (bus.WLS)
      2'b00:   n_load = CNT_W'(N5);
      2'b01:   n_load = CNT_W'(N6);
      2'b10:   n_load = CNT_W'(N7);
      default: n_load = CNT_W'(N8);
    endcase
    if (bus.ovr_clr) overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SEND;
          word_d  = bus.data_in;
          wls_d   = bus.WLS;
          n_d     = n_load;
          idx_d   = '0;
        end
      end
      SEND: begin
        // A load attempt while busy is dropped; set beats a same-cycle clear.
        if (load) overrun_d = 1'b1;
        if (bus.out_ready) begin
          if (idx_q == n_q - CNT_W'(1)) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Chunk select from the latched word; the word is implicitly zero-padded above IN_W-1.
  always_comb begin
    width      = 4'd5 + {2'b00, wls_q};
    sel        = MSB_FIRST ? (n_q - CNT_W'(1) - idx_q) : idx_q;
    shamt      = SH_W'(sel) * SH_W'(width);
    shifted    = word_q >> shamt;
    chunk_mask = 8'hFF >> (4'd8 - width);
    chunk      = shifted[7:0] & chunk_mask;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_last  = (state_q == SEND) && (idx_q == n_q - CNT_W'(1));
  assign bus.data_out  = (state_q == SEND) ? OUT_W'(chunk) : '0;
  assign bus.overrun   = overrun_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_uart_tx_word_splitter.sv
// Randomized bench for uart_tx_word_splitter with a chunk-list reference model.
module tb_uart_tx_word_splitter;
  localparam logic [7:0] TX_ADDR = 8'h00;

  logic m_clk;
  logic reset;
  logic state_dbg;
  int   n_checks;
  int   n_fail;
  logic exp_ovr;
  logic [7:0] exp_q[$];

  uart_tx_word_splitter_if #(.ADDR_W(8), .IN_W(16), .OUT_W(8)) bus ();

  uart_tx_word_splitter #(
    .IN_W(16), .OUT_W(8), .ADDR_W(8), .TX_ADDR(TX_ADDR), .MSB_FIRST(1'b0)
  ) dut (
    .m_clk(m_clk),
    .reset(reset),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // Clock
  initial m_clk = 1'b0;
  always #5 m_clk = ~m_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge m_clk);
    #1;
  endtask

  // Build the expected character list straight from the word-length rules.
  task automatic model_word(input logic [15:0] word, input logic [1:0] wls);
    int w, n, wi, ch;
    w  = 5 + int'(wls);
    n  = (16 + w - 1) / w;
    wi = int'(word);
    for (int k = 0; k < n; k++) begin
      ch = (wi >> (k * w)) % (1 << w);
      exp_q.push_back(8'(ch));
    end
  endtask

  task automatic do_write(input logic [15:0] word, input logic [1:0] wls, input logic [7:0] addr);
    bus.wr_en   = 1'b1;
    bus.address = addr;
    bus.data_in = word;
    bus.WLS     = wls;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // ovr_mode: 0 none, 1 load attempt on the first busy cycle, 2 same with ovr_clr.
  task automatic send_word(input logic [15:0] word, input logic [1:0] wls,
                           input int hold, input bit rnd_ready, input int ovr_mode);
    int   cyc;
    logic rdy;
    check("in_ready_before", bus.in_ready, 1);
    model_word(word, wls);
    do_write(word, wls, TX_ADDR);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      check("valid", bus.out_valid, 1);
      check("in_ready_busy", bus.in_ready, 0);
      check("data", bus.data_out, exp_q[0]);
      check("last", bus.out_last, exp_q.size() == 1);
      rdy = (cyc < hold) ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      bus.out_ready = rdy;
      bus.WLS       = 2'($urandom_range(0, 3));
      bus.data_in   = 16'($urandom);
      if (cyc == 0 && ovr_mode != 0) begin
        bus.wr_en   = 1'b1;
        bus.address = TX_ADDR;
        bus.ovr_clr = (ovr_mode == 2);
        exp_ovr     = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.wr_en   = 1'b1;
        bus.address = 8'h01;
      end
      tick();
      bus.wr_en     = 1'b0;
      bus.ovr_clr   = 1'b0;
      bus.out_ready = 1'b0;
      check("overrun", bus.overrun, exp_ovr);
      if (rdy) void'(exp_q.pop_front());
      cyc++;
    end
    check("word_done_in_budget", exp_q.size(), 0);
    exp_q.delete();
    check("valid_after", bus.out_valid, 0);
    check("in_ready_after", bus.in_ready, 1);
    check("last_after", bus.out_last, 0);
  endtask

  task automatic clear_overrun();
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    exp_ovr = 1'b0;
    check("ovr_clr", bus.overrun, 0);
  endtask

  // Stimulus
  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_ovr  = 1'b0;
    reset = 1'b0;
    bus.address = '0; bus.wr_en = 1'b0; bus.data_in = '0; bus.WLS = '0;
    bus.out_ready = 1'b0; bus.ovr_clr = 1'b0;
    tick(); tick();
    check("rst_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_data", bus.data_out, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_overrun", bus.overrun, 0);
    reset = 1'b1;
    tick();

    // Directed cases from the character-width table
    send_word(16'hA55A, 2'b11, 0, 1'b0, 0);
    send_word(16'hA55A, 2'b10, 0, 1'b0, 0);
    send_word(16'hFFFF, 2'b00, 0, 1'b0, 0);
    send_word(16'h1234, 2'b11, 5, 1'b0, 0);
    send_word(16'hC3A7, 2'b01, 0, 1'b0, 1);
    clear_overrun();
    send_word(16'h5E21, 2'b10, 0, 1'b0, 2);
    clear_overrun();

    // Write to another address is not a load
    do_write(16'h1111, 2'b11, 8'h01);
    check("badaddr_valid", bus.out_valid, 0);
    check("badaddr_in_ready", bus.in_ready, 1);

    // Reset mid-word discards the rest; set overrun first so reset clearing it is visible
    bus.out_ready = 1'b1;
    do_write(16'hBEEF, 2'b11, TX_ADDR);
    check("beef_chunk0", bus.data_out, 8'hEF);
    bus.wr_en = 1'b1; bus.address = TX_ADDR;
    tick();
    bus.wr_en = 1'b0; bus.out_ready = 1'b0;
    check("beef_chunk1", bus.data_out, 8'hBE);
    check("beef_ovr", bus.overrun, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_ovr = 1'b0;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_data", bus.data_out, 0);
    check("midrst_overrun", bus.overrun, 0);
    send_word(16'hBEEF, 2'b11, 0, 1'b0, 0);

    // Random words, widths, back-pressure and idle gaps
    for (int i = 0; i < 40; i++) begin
      send_word(16'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                1'b1, ($urandom_range(0, 7) == 0) ? 1 : 0);
      if (exp_ovr) clear_overrun();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
